// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks in-flight destination registers (64 busy bits),
// blocks instructions with RAW/WAW hazards, and holds one registered issue
// slot toward the register-file stage. A small RUN/DRAIN FSM quiesces the
// pipeline on request.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   instr_valid, instr   upstream instruction (op[31:26] rd[25:20] rs[19:14] rt[13:8])
//   instr_ready          instruction accepted when high with instr_valid
//   wb_valid, wb_addr    writeback completion clears a busy bit
//   drain_req            request to quiesce
//   drain_done           one-cycle pulse when the drain completes
//   iss_valid, iss_ready issue handshake downstream
//   iss_op/rd/rs/rt      registered decoded fields
//   stall_cnt            saturating count of hazard stall cycles
module issue_scoreboard #(
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  input  logic               wb_valid,
  input  logic [5:0]         wb_addr,
  input  logic               drain_req,
  output logic               drain_done,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [5:0]         iss_op,
  output logic [5:0]         iss_rd,
  output logic [5:0]         iss_rs,
  output logic [5:0]         iss_rt,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state, state_next;
  logic [63:0] busy, busy_n, busy_next;
  logic [5:0]  op, rd, rs, rt;
  logic        hazard, slot_free, accept, iss_valid_next;
  logic        unused_low;

  assign op = instr[31:26];
  assign rd = instr[25:20];
  assign rs = instr[19:14];
  assign rt = instr[13:8];
  assign unused_low = ^instr[7:0];

  // Writeback in this cycle already unblocks dependants in this cycle.
  always_comb begin
    busy_n = busy;
    if (wb_valid) busy_n[wb_addr] = 1'b0;
  end

  assign hazard    = busy_n[rs] | busy_n[rt] | busy_n[rd];
  assign slot_free = ~iss_valid | iss_ready;

  // drain_req pre-empts an accept in the same cycle.
  assign instr_ready = rstn & (state == RUN) & ~drain_req & ~hazard & slot_free;
  assign accept      = instr_valid & instr_ready;

  // Set of the new destination is applied after the writeback clear,
  // so a same-edge set wins.
  always_comb begin
    busy_next = busy_n;
    if (accept && rd != 6'd0) busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign iss_valid_next = accept | (iss_valid & ~iss_ready);

  // Drain completion looks at post-update state so the pulse and the
  // return to RUN coincide with the edge that empties the pipeline.
  always_comb begin
    state_next = state;
    drain_done = 1'b0;
    case (state)
      RUN: begin
        if (drain_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (busy_next == '0 && !iss_valid_next) begin
          drain_done = rstn;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= RUN;
      busy      <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_rd    <= '0;
      iss_rs    <= '0;
      iss_rt    <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_next;
      busy      <= busy_next;
      iss_valid <= iss_valid_next;
      if (accept) begin
        iss_op <= op;
        iss_rd <= rd;
        iss_rs <= rs;
        iss_rt <= rt;
      end
      if (instr_valid && hazard && state == RUN && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Testbench for issue_scoreboard: directed vector tables, a stall saturation
// run, a mid-operation reset sequence and a randomized phase compared against
// an array-based reference model.
module tb_issue_scoreboard;

  localparam int unsigned SW   = 16;
  localparam int unsigned SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rstn, instr_valid, wb_valid, drain_req, iss_ready;
  logic [31:0]   instr;
  logic [5:0]    wb_addr;
  logic          instr_ready, drain_done, iss_valid;
  logic [5:0]    iss_op, iss_rd, iss_rs, iss_rt;
  logic [SW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  issue_scoreboard #(.STALL_W(SW)) dut (
    .clk(clk), .rstn(rstn), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .drain_req(drain_req), .drain_done(drain_done), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .iss_op(iss_op), .iss_rd(iss_rd), .iss_rs(iss_rs),
    .iss_rt(iss_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          iv;
    logic [31:0]   ins;
    logic          wbv;
    logic [5:0]    wba;
    logic          dr;
    logic          issr;
    logic          e_ready;
    logic          e_done;
    logic          e_valid;
    logic [23:0]   e_fields;
    logic [SW-1:0] e_stall;
  } vec_t;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
    logic [5:0] a, b, c, d;
    a = 6'(op); b = 6'(rd); c = 6'(rs); d = 6'(rt);
    return {a, b, c, d, 8'h00};
  endfunction

  function automatic vec_t v(input logic r, input logic iv, input logic [31:0] ins,
                             input logic wbv, input int wba, input logic dr, input logic issr,
                             input logic er, input logic ed, input logic ev,
                             input logic [31:0] eins, input int es);
    vec_t t;
    t.rst_n = r; t.iv = iv; t.ins = ins; t.wbv = wbv; t.wba = 6'(wba);
    t.dr = dr; t.issr = issr; t.e_ready = er; t.e_done = ed; t.e_valid = ev;
    t.e_fields = eins[31:8]; t.e_stall = SW'(es);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] ins, input logic wbv,
                       input logic [5:0] wba, input logic dr, input logic issr);
    rstn = r; instr_valid = iv; instr = ins; wb_valid = wbv;
    wb_addr = wba; drain_req = dr; iss_ready = issr;
  endtask

  // Entered and left at posedge+1.
  task automatic run_vec(input vec_t t, input string tag);
    drive(t.rst_n, t.iv, t.ins, t.wbv, t.wba, t.dr, t.issr);
    #3;
    chk({tag, " instr_ready"}, 32'(instr_ready), 32'(t.e_ready));
    chk({tag, " drain_done"}, 32'(drain_done), 32'(t.e_done));
    @(posedge clk); #1;
    chk({tag, " iss_valid"}, 32'(iss_valid), 32'(t.e_valid));
    chk({tag, " iss_fields"}, 32'({iss_op, iss_rd, iss_rs, iss_rt}), 32'(t.e_fields));
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(t.e_stall));
  endtask

  task automatic run_list(input vec_t q[$], input string tag);
    foreach (q[i]) run_vec(q[i], $sformatf("%s[%0d]", tag, i));
  endtask

  // Reference model: state after the most recent edge.
  bit          mb[64];
  bit          mv;
  logic [23:0] mf;
  int unsigned ms;
  bit          md;

  task automatic model_cycle(output bit rdy, output bit done);
    bit bn[64];
    bit hz, acc, empty;
    int rd, rs, rt;
    rd = int'(instr[25:20]); rs = int'(instr[19:14]); rt = int'(instr[13:8]);
    for (int i = 0; i < 64; i++) bn[i] = mb[i] && !(wb_valid && int'(wb_addr) == i);
    hz   = bn[rs] || bn[rt] || bn[rd];
    rdy  = rstn && !md && !drain_req && !hz && (!mv || iss_ready);
    acc  = instr_valid && rdy;
    done = 1'b0;
    if (!rstn) begin
      for (int i = 0; i < 64; i++) mb[i] = 1'b0;
      mv = 1'b0; mf = '0; ms = 0; md = 1'b0;
    end else begin
      if (instr_valid && hz && !md && ms < SMAX) ms++;
      for (int i = 0; i < 64; i++) mb[i] = bn[i];
      if (acc && rd != 0) mb[rd] = 1'b1;
      if (acc) begin mv = 1'b1; mf = instr[31:8]; end
      else if (iss_ready) mv = 1'b0;
      if (!md) md = drain_req;
      else begin
        empty = 1'b1;
        for (int i = 0; i < 64; i++) if (mb[i]) empty = 1'b0;
        if (empty && !mv) begin done = 1'b1; md = 1'b0; end
      end
    end
  endtask

  vec_t tbl[$];
  vec_t seq_a[$];
  vec_t seq_b[$];

  initial begin
    logic [31:0] Z;
    Z = 32'h0;
    drive(1'b0, 1'b0, Z, 1'b0, 6'd0, 1'b0, 1'b0);

    // Hazard, writeback bypass, backpressure, rd=0 stream, set-wins, stray wb.
    tbl.push_back(v(0,1,mk(1,5,1,2),0,0,0,1, 0,0,0,Z,0));
    tbl.push_back(v(1,1,mk(1,5,1,2),0,0,0,1, 1,0,1,mk(1,5,1,2),0));
    tbl.push_back(v(1,1,mk(2,6,5,3),0,0,0,1, 0,0,0,mk(1,5,1,2),1));
    tbl.push_back(v(1,1,mk(2,6,5,3),0,0,0,1, 0,0,0,mk(1,5,1,2),2));
    tbl.push_back(v(1,1,mk(2,6,5,3),1,5,0,1, 1,0,1,mk(2,6,5,3),2));
    tbl.push_back(v(1,1,mk(3,7,0,0),0,0,0,0, 0,0,1,mk(2,6,5,3),2));
    tbl.push_back(v(1,1,mk(3,7,0,0),0,0,0,0, 0,0,1,mk(2,6,5,3),2));
    tbl.push_back(v(1,1,mk(3,7,0,0),0,0,0,0, 0,0,1,mk(2,6,5,3),2));
    tbl.push_back(v(1,1,mk(3,7,0,0),0,0,0,1, 1,0,1,mk(3,7,0,0),2));
    tbl.push_back(v(1,1,Z,0,0,0,1, 1,0,1,Z,2));
    tbl.push_back(v(1,1,Z,0,0,0,1, 1,0,1,Z,2));
    tbl.push_back(v(1,1,Z,0,0,0,1, 1,0,1,Z,2));
    tbl.push_back(v(1,0,Z,1,6,0,1, 1,0,0,Z,2));
    tbl.push_back(v(1,0,Z,1,7,0,1, 1,0,0,Z,2));
    tbl.push_back(v(1,1,mk(4,9,0,0),1,9,0,1, 1,0,1,mk(4,9,0,0),2));
    tbl.push_back(v(1,1,mk(5,10,9,0),0,0,0,1, 0,0,0,mk(4,9,0,0),3));
    tbl.push_back(v(1,1,mk(5,10,9,0),1,9,0,1, 1,0,1,mk(5,10,9,0),3));
    tbl.push_back(v(1,0,Z,1,33,0,1, 1,0,0,mk(5,10,9,0),3));
    tbl.push_back(v(1,0,Z,1,10,0,1, 1,0,0,mk(5,10,9,0),3));

    // Drain of an empty pipeline; drain_req repeated while draining.
    seq_a.push_back(v(1,1,mk(1,3,0,0),0,0,1,1, 0,0,0,mk(5,10,9,0),3));
    seq_a.push_back(v(1,1,mk(1,3,0,0),0,0,1,1, 0,1,0,mk(5,10,9,0),3));
    seq_a.push_back(v(1,1,mk(1,3,0,0),0,0,0,1, 1,0,1,mk(1,3,0,0),3));

    // Drain waiting on a held issue slot and on busy[7].
    seq_b.push_back(v(1,1,mk(2,7,0,0),0,0,0,1, 1,0,1,mk(2,7,0,0),3));
    seq_b.push_back(v(1,0,Z,1,3,1,0, 0,0,1,mk(2,7,0,0),3));
    seq_b.push_back(v(1,1,Z,0,0,1,0, 0,0,1,mk(2,7,0,0),3));
    seq_b.push_back(v(1,1,Z,0,0,0,1, 0,0,0,mk(2,7,0,0),3));
    seq_b.push_back(v(1,1,Z,1,7,0,1, 0,1,0,mk(2,7,0,0),3));
    seq_b.push_back(v(1,1,Z,0,0,0,1, 1,0,1,Z,3));
    seq_b.push_back(v(1,0,Z,0,0,0,1, 1,0,0,Z,3));

    @(posedge clk); #1;
    run_list(tbl, "tbl");
    run_list(seq_a, "drain_empty");
    run_list(seq_b, "drain_busy");

    // Stall counter saturation over 2^16+3 hazard cycles.
    run_vec(v(0,0,Z,0,0,0,1, 0,0,0,Z,0), "sat_reset");
    run_vec(v(1,1,mk(1,5,0,0),0,0,0,1, 1,0,1,mk(1,5,0,0),0), "sat_setup");
    drive(1'b1, 1'b1, mk(1,8,5,0), 1'b0, 6'd0, 1'b0, 1'b1);
    #3;
    chk("sat ready", 32'(instr_ready), 32'd0);
    repeat ((1 << SW) - 2) @(posedge clk);
    #1;
    chk("sat stall_max_minus1", 32'(stall_cnt), 32'(SMAX - 1));
    chk("sat iss_valid", 32'(iss_valid), 32'd0);
    @(posedge clk); #1;
    chk("sat stall_max", 32'(stall_cnt), 32'(SMAX));
    repeat (4) @(posedge clk);
    #1;
    chk("sat stall_hold", 32'(stall_cnt), 32'(SMAX));

    // Reset mid-operation with a held slot; stale writeback afterwards.
    run_vec(v(1,1,mk(1,9,0,0),0,0,0,1, 1,0,1,mk(1,9,0,0),SMAX), "midrst_a");
    run_vec(v(1,0,Z,0,0,0,0, 0,0,1,mk(1,9,0,0),SMAX), "midrst_b");
    run_vec(v(0,1,mk(1,9,0,0),0,0,0,0, 0,0,0,Z,0), "midrst_c");
    run_vec(v(1,1,mk(2,11,5,9),1,5,0,0, 1,0,1,mk(2,11,5,9),0), "midrst_d");

    // Randomized phase against the reference model.
    for (int n = 0; n < 1500; n++) begin
      bit rdy_m, done_m;
      logic [31:0] ins;
      ins = {6'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
             6'($urandom_range(0, 7)), 8'($urandom)};
      drive((n == 0) ? 1'b0 : ($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), ins,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      model_cycle(rdy_m, done_m);
      #3;
      chk($sformatf("rnd[%0d] instr_ready", n), 32'(instr_ready), 32'(rdy_m));
      chk($sformatf("rnd[%0d] drain_done", n), 32'(drain_done), 32'(done_m));
      @(posedge clk); #1;
      chk($sformatf("rnd[%0d] iss_valid", n), 32'(iss_valid), 32'(mv));
      if (mv)
        chk($sformatf("rnd[%0d] iss_fields", n), 32'({iss_op, iss_rd, iss_rs, iss_rt}), 32'(mf));
      chk($sformatf("rnd[%0d] stall_cnt", n), 32'(stall_cnt), ms);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter: STALL_W, 16, width of the saturating stall counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 instr_valid  input  1  upstream instruction present.
REQ-005 instr  input  32  instruction; op=[31:26], rd=[25:20], rs=[19:14], rt=[13:8].
REQ-006 instr_ready  output  1  instruction accepted this cycle when high with instr_valid.
REQ-007 wb_valid  input  1  writeback completion strobe from the register-file stage.
REQ-008 wb_addr  input  6  register whose result has been written.
REQ-009 drain_req  input  1  request to quiesce the pipeline.
REQ-010 drain_done  output  1  one-cycle pulse when drain completes.
REQ-011 iss_valid, iss_ready  output/input  1 each  issue handshake to the register-file stage.
REQ-012 iss_op, iss_rd, iss_rs, iss_rt  output  6 each  registered decoded fields.
REQ-013 stall_cnt  output  STALL_W  saturating count of hazard stall cycles.

Function
REQ-014 Scoreboard: 64 busy bits, one per register; busy[0] always reads 0 and is never set.
REQ-015 hazard = busy_n[rs] | busy_n[rt] | busy_n[rd]; busy_n = busy with this cycle's wb_addr bit cleared when wb_valid (writeback unblocks in the same cycle).
REQ-016 slot_free = ~iss_valid | iss_ready.
REQ-017 instr_ready = (state==RUN) & ~hazard & slot_free; combinational, permitted to depend on instr.
REQ-018 On accept (instr_valid & instr_ready): next cycle iss_valid=1 and iss_* hold the accepted fields; latency exactly 1 cycle.
REQ-019 On accept with rd!=0: busy[rd] set at the same edge.
REQ-020 Same-edge set of busy[rd] and wb clear of the same register: set wins.
REQ-021 wb_valid for a register not busy: no effect, no error.
REQ-022 iss_valid & ~iss_ready: iss_* held stable; no new accept.
REQ-023 iss_valid & iss_ready & no accept: iss_valid drops to 0 next cycle.
REQ-024 stall_cnt increments by 1 each cycle with instr_valid & hazard & state==RUN; saturates at all-ones; never wraps.
REQ-025 FSM states RUN, DRAIN. RUN->DRAIN when drain_req=1 (drain_req takes priority over an accept in the same cycle: instr_ready=0).
REQ-026 In DRAIN: instr_ready=0; when all busy bits are 0 and iss_valid=0 (evaluated after this cycle's updates), drain_done pulses for 1 cycle and state returns to RUN.
REQ-027 drain_req asserted while already in DRAIN: ignored; drain_done pulses exactly once per DRAIN entry.
REQ-028 Drain with an empty pipeline: RUN->DRAIN at edge N, drain_done=1 during cycle N+1, RUN at edge N+1.

Reset
REQ-029 rstn=0 at a rising edge: all busy bits 0, iss_valid=0, iss_* fields 0, stall_cnt=0, drain_done=0, state=RUN.
REQ-030 Reset mid-operation discards the held issue slot and all busy bits; pending writebacks after reset are ignored per REQ-021.
REQ-031 While rstn=0, instr_ready=0.

Verification
REQ-032 Accept instr rd=5, rs=1, rt=2, iss_ready=1 -> next cycle iss_valid=1, iss_rd=5, busy[5]=1; second instr with rs=5 -> instr_ready=0, stall_cnt increments each cycle.
REQ-033 With busy[5] set, wb_valid=1, wb_addr=5 in the same cycle as instr rs=5 -> instr_ready=1, accepted, no stall counted.
REQ-034 iss_ready=0 for 3 cycles with iss_valid=1 -> iss_* unchanged, instr_ready=0; iss_ready=1 -> slot drains/refills.
REQ-035 rd=0 instructions back-to-back, all fields 0 -> accepted every cycle, busy remains all 0.
REQ-036 Force 2^STALL_W+3 hazard cycles -> stall_cnt stays at all-ones.
REQ-037 drain_req with busy[7] set -> instr_ready=0; wb_addr=7, iss slot empty -> single drain_done pulse, state RUN, accepts resume.
